seq_restoring_divider: RTL and testbench

- Sequential unsigned restoring divider; the inverse-operation companion to the Dadda multiplier datapath.
- Produces one quotient bit per clock cycle.
- Fronted by a start/done handshake.
- Sits beside the multiplier in the arithmetic unit; consumes operands from the same operand registers and returns quotient and remainder to the result mux.

---
 rtl/seq_restoring_divider_pkg.sv | 13 +
 rtl/seq_restoring_divider_if.sv | 26 ++
 rtl/seq_restoring_divider_div_trial_sub.sv | 32 +++
 rtl/seq_restoring_divider.sv | 113 +++++++++++
 tb/tb_seq_restoring_divider.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/seq_restoring_divider_pkg.sv
// Shared arithmetic-unit constants: divider FSM encoding and default operand width
// (the default width is common to the divider and the Dadda multiplier).
package seq_restoring_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } div_state_e;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake and operand/result bus between the operand registers,
// the divider and the result mux.
interface seq_restoring_divider_if #(
  parameter int WIDTH = seq_restoring_divider_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_restoring_divider_div_trial_sub.sv
// Trial subtractor P - {0,divisor}: ripple of full adders, divisor inverted, carry-in 1.
// Purely combinational; the sign bit of the WIDTH+1-bit result becomes the non-negative flag.
module div_trial_sub
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   p_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             nonneg_o
);

  logic [WIDTH:0] b_inv;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] carry;

  assign b_inv    = ~{1'b0, divisor_i};
  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign sum[i] = p_i[i] ^ b_inv[i] ^ carry[i];
    if (i < WIDTH) begin : g_carry
      assign carry[i+1] = (p_i[i] & b_inv[i]) | (p_i[i] & carry[i]) | (b_inv[i] & carry[i]);
    end
  end

  // |T| < 2^WIDTH always holds, so the top sum bit is a true sign bit.
  assign diff_o   = sum[WIDTH-1:0];
  assign nonneg_o = ~sum[WIDTH];

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses WIDTH+1 cycles after
// start (1 cycle for divide-by-zero). Start is ignored while busy; accepted in IDLE or FIN.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  seq_restoring_divider_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH-1:0] trial_diff;
  logic             trial_nonneg;
  logic [WIDTH-1:0] p_nxt;
  logic [WIDTH-1:0] q_nxt;

  // P stays below the divisor between iterations, so WIDTH bits hold it; only the
  // shifted value needs the extra bit.
  assign p_shift = {p_q, q_q[WIDTH-1]};

  div_trial_sub #(.WIDTH(WIDTH)) u_trial (
    .p_i       (p_shift),
    .divisor_i (dvsr_q),
    .diff_o    (trial_diff),
    .nonneg_o  (trial_nonneg)
  );

  assign p_nxt = trial_nonneg ? trial_diff : p_shift[WIDTH-1:0];
  assign q_nxt = {q_q[WIDTH-2:0], trial_nonneg};

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      RUN: begin
        p_d   = p_nxt;
        q_d   = q_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIN;
          quot_d  = q_nxt;
          rem_d   = p_nxt;
          dbz_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        if (bus.start) begin
          if (bus.divisor != '0) begin
            p_d     = '0;
            q_d     = bus.dividend;
            dvsr_d  = bus.divisor;
            cnt_d   = CW'(WIDTH);
            state_d = RUN;
          end else begin
            quot_d  = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = FIN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == FIN);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and random checks of seq_restoring_divider at WIDTH=8.
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_restoring_divider_if #(.WIDTH(W)) bus ();

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the current sample point until done is seen (bounded).
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  // Drives a one-cycle start, scrambles operands afterwards, waits for done.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int busy_cnt);
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    tick();
    bus.start = 1'b0;
    bus.dividend = 8'hAA;
    bus.divisor = 8'h55;
    wait_done(lat, busy_cnt);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] eq, input logic [W-1:0] er,
                              input logic edbz, input int elat);
    int lat;
    int bc;
    do_op(a, b, lat, bc);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_busy_cycles"}, bc, elat);
    chk({tag, "_q"}, bus.quotient, eq);
    chk({tag, "_r"}, bus.remainder, er);
    chk({tag, "_dbz"}, bus.div_by_zero, edbz);
    tick();
    chk({tag, "_done_pulse"}, bus.done, 1'b0);
  endtask

  initial begin
    int lat;
    int bc;
    int seen;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hq;
    logic [W-1:0] hr;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_q", bus.quotient, 0);
    chk("rst_r", bus.remainder, 0);
    chk("rst_dbz", bus.div_by_zero, 1'b0);

    // Directed arithmetic: done visible in the cycle after edge E8
    check_result("basic_100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);
    check_result("small_5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 8);
    check_result("max_255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
    check_result("eq_255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 8);
    check_result("dbz_200_0", 8'd200, 8'd0, 8'hFF, 8'd200, 1'b1, 0);
    check_result("after_dbz_20_3", 8'd20, 8'd3, 8'd6, 8'd2, 1'b0, 8);

    // Results hold through IDLE
    repeat (5) tick();
    chk("hold_q", bus.quotient, 8'd6);
    chk("hold_r", bus.remainder, 8'd2);

    // start re-pulsed during RUN is ignored
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
    tick();
    bus.start = 1'b0;
    wait_done(lat, bc);
    chk("ignore_lat", lat, 4);
    chk("ignore_q", bus.quotient, 8'd14);
    chk("ignore_r", bus.remainder, 8'd2);

    // start held high in FIN: back-to-back
    bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
    tick();
    chk("b2b_busy", bus.busy, 1'b1);
    chk("b2b_done_low", bus.done, 1'b0);
    bus.start = 1'b0;
    wait_done(lat, bc);
    chk("b2b_lat", lat, 8);
    chk("b2b_q", bus.quotient, 8'd10);
    chk("b2b_r", bus.remainder, 8'd0);
    tick();

    // Reset mid-RUN
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    chk("midrst_q", bus.quotient, 0);
    chk("midrst_r", bus.remainder, 0);
    chk("midrst_dbz", bus.div_by_zero, 1'b0);
    seen = 0;
    repeat (12) begin
      tick();
      if (bus.done) seen++;
    end
    chk("midrst_no_done", seen, 0);
    check_result("post_rst_9_2", 8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 8);

    // rst and start together: start dropped
    rst = 1'b1;
    bus.start = 1'b1; bus.dividend = 8'd30; bus.divisor = 8'd3;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    chk("rst_start_busy", bus.busy, 1'b0);
    tick();
    chk("rst_start_done", bus.done, 1'b0);
    chk("rst_start_q", bus.quotient, 0);

    // Random operands against the division invariant
    for (int n = 0; n < 500; n++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      do_op(a, b, lat, bc);
      if (b == 0) begin
        chk("rnd_dbz_lat", lat, 0);
        chk("rnd_dbz_q", bus.quotient, 8'hFF);
        chk("rnd_dbz_r", bus.remainder, a);
        chk("rnd_dbz_flag", bus.div_by_zero, 1'b1);
      end else begin
        chk("rnd_lat", lat, 8);
        chk("rnd_inv", 32'(bus.quotient) * 32'(b) + 32'(bus.remainder), 32'(a));
        chk("rnd_rem_lt", 32'(bus.remainder < b), 1);
        chk("rnd_dbz_clr", bus.div_by_zero, 1'b0);
      end
      hq = bus.quotient;
      hr = bus.remainder;
      repeat ($urandom_range(1, 3)) tick();
      chk("rnd_hold_q", bus.quotient, hq);
      chk("rnd_hold_r", bus.remainder, hr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
